// File: rtl/adder_pkg.sv
// Shared types for the serial arithmetic blocks.
// The three-state sequencing enum is common to every bit-serial unit.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

endpackage

// File: rtl/one_bit_fulladder.sv
// Single-bit full adder; the only arithmetic cell in the serial adder.
module one_bit_fulladder (
  input  logic A,
  input  logic B,
  input  logic cin,
  output logic S,
  output logic cout
);

  assign S    = A ^ B ^ cin;
  assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that streams operands LSB-first through one full adder,
// one bit per clock, and presents the reassembled sum in parallel.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sadd_state_t      state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_cout;

  one_bit_fulladder u_fa (
    .S    (fa_s),
    .cout (fa_cout),
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .cin  (carry_q)
  );

  // The freshly computed bit enters at the MSB so the LSB lands at bit 0
  // after WIDTH shifts.
  assign sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};

  // NOTE: every state element uses non-blocking assignment so all registers
  // sample the same pre-edge values; the reset branch clears datapath
  // registers too, so an aborted run leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_cout;
          cnt_q    <= cnt_q + 1'b1;
          // Final bit goes straight to the outputs from the adder itself.
          if (cnt_q == LAST_BIT) begin
            sum_q   <= sum_sh_d;
            cout_q  <= fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
